// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the FSM state type and the rotating priority search.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // First set request at or after ptr, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] res;
    logic             found;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = ptr + IDX_W'(i);
      if (!found && req[k]) begin
        res   = k;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// Enabled 3-to-8 one-hot decoder.
// Output is all zero while en is low.
module decoder3to8 (
  input  logic [2:0] A,
  input  logic       en,
  output logic [7:0] Y
);

  assign Y = en ? (8'h01 << A) : 8'h00;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters share one select resource.
// Grant is held until done, request withdrawal, or hold limit.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_idx;
  logic [HOLD_W-1:0] r_hold;
  logic [IDX_W-1:0]  w_pick;
  logic              w_rel;
  logic              w_to;
  logic              w_en;

  assign w_pick = rr_pick(req, r_ptr);
  assign w_en   = (r_state == GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_idx  <= w_pick;
            r_hold <= '0;
          end
        end
        GRANT: begin
          r_hold <= r_hold + HOLD_W'(1);
          if (w_rel)
            r_ptr <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // done beats withdrawal beats the hold limit, so timeout
  // only fires when the owner is still requesting.
  always_comb begin
    w_next = r_state;
    w_rel  = 1'b0;
    w_to   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req)
          w_next = GRANT;
      end
      GRANT: begin
        if (done) begin
          w_rel = 1'b1;
        end else if (!req[r_idx]) begin
          w_rel = 1'b1;
        end else if (r_hold == HOLD_W'(MAX_HOLD - 1)) begin
          w_rel = 1'b1;
          w_to  = 1'b1;
        end
        if (w_rel)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  decoder3to8 u_dec (
    .A  (r_idx),
    .en (w_en),
    .Y  (gnt)
  );

  assign gnt_idx   = r_idx;
  assign gnt_valid = w_en;
  assign timeout   = w_to;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 against a behavioural model.
// Driver pushes expected outputs; a negedge monitor compares.
module tb_rr_arbiter8;

  localparam int MAXH = 16;

  typedef struct {
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] idx;
    logic       to;
    bit         chk_idx;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  exp_t q[$];
  int   seq[$];
  int   checks;
  int   errors;
  int   n_to;
  logic prev_vld;

  // model state
  bit m_busy;
  int m_owner;
  int m_held;
  int m_ptr;

  rr_arbiter8 #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One cycle: apply inputs, predict outputs, advance model at edge.
  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    req  = r;
    done = d;
    rst  = rs;
    e.gnt     = m_busy ? 8'(1 << m_owner) : 8'h00;
    e.vld     = m_busy;
    e.idx     = m_busy ? 3'(m_owner) : 3'd0;
    e.to      = m_busy && !d && r[m_owner] && (m_held == MAXH - 1);
    e.chk_idx = m_busy;
    q.push_back(e);
    @(posedge clk);
    if (rs) begin
      m_busy = 0;
      m_ptr  = 0;
      m_held = 0;
    end else if (m_busy) begin
      if (d || !r[m_owner] || m_held == MAXH - 1) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 8;
      end else begin
        m_held++;
      end
    end else if (r != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          break;
        end
      end
      m_busy = 1;
      m_held = 0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt", gnt, e.gnt);
      chk("gnt_valid", gnt_valid, e.vld);
      chk("timeout", timeout, e.to);
      if (e.chk_idx)
        chk("gnt_idx", gnt_idx, e.idx);
      if (timeout === 1'b1)
        n_to++;
      if (gnt_valid === 1'b1 && prev_vld !== 1'b1)
        seq.push_back(int'(gnt_idx));
      prev_vld = gnt_valid;
    end
  end

  initial begin
    logic [7:0] r;
    int waitc;
    checks = 0; errors = 0; n_to = 0; prev_vld = 1'b0;
    m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0;
    rst = 1'b1; req = 8'h00; done = 1'b0;
    @(posedge clk);
    #1;

    // idle with no requests; reset state incl. gnt_idx
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
    chk("rst_idx", gnt_idx, 0);

    // single requester 2, done after 3 grant cycles
    step(8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h05, 1'b0, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // all-ones rotation, done on second grant cycle
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    seq.delete();
    for (int i = 0; i < 30; i++)
      step(8'hFF, m_busy && m_held == 1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("rot_count", seq.size() >= 9, 1);
    for (int i = 0; i < 9 && i < seq.size(); i++)
      chk("rot_owner", seq[i], i % 8);

    // hold-limit timeout with lone requester 0
    step(8'h00, 1'b0, 1'b1);
    n_to = 0;
    for (int i = 0; i < 18; i++) step(8'h01, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    chk("to_once", n_to, 1);
    for (int i = 0; i < 16; i++) step(8'h01, 1'b0, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("to_twice", n_to, 2);

    // owner 5 withdraws while 6 waits
    step(8'h00, 1'b0, 1'b1);
    step(8'h60, 1'b0, 1'b0);
    step(8'h60, 1'b0, 1'b0);
    step(8'h40, 1'b0, 1'b0);
    step(8'h40, 1'b0, 1'b0);
    step(8'h40, 1'b0, 1'b0);
    step(8'h40, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // reset while owner 3 holds
    step(8'h00, 1'b0, 1'b1);
    step(8'h88, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b1);
    step(8'h88, 1'b0, 1'b0);
    step(8'h88, 1'b0, 1'b0);
    step(8'h88, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // randomized traffic
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        r = 8'($urandom_range(0, 255));
      step(r, $urandom_range(0, 23) == 0,
           $urandom_range(0, 299) == 0);
    end
    step(8'h00, 1'b0, 1'b0);

    waitc = 0;
    while (q.size() > 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way select resource between 8 requesters.
- Picks one winner per arbitration and holds the grant until the winner signals done, withdraws its request, or exceeds a hold limit.
- Drives a one-hot grant through the team's enabled 3-to-8 decoder.
- Sits between requesting engines and a shared bus or chip-select fabric.

Parameters:
- MAX_HOLD, default 16: maximum cycles a grant is held before forced release. Legal range 2..255.
- HOLD_W, default 8: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset. Synchronous, active-high.
- req  input  8  request vector; bit i is requester i.
- done  input  1  current owner finished; sampled only in GRANT.
- gnt  output  8  one-hot grant; all zero when no grant is active.
- gnt_idx  output  3  index of the current owner; valid while gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- One clock domain (clk). rst is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit searching ptr, ptr+1, …, ptr+7 (mod 8).
  - Register the winner into idx, clear hold_cnt, go to GRANT.
  - gnt, gnt_valid and gnt_idx become visible the next cycle, so req→gnt latency is 1 cycle.
- GRANT:
  - gnt = decoder(idx, en=1); gnt_valid=1; gnt_idx=idx.
  - hold_cnt increments every cycle.
  - Release condition, evaluated each cycle (first match wins):
    - done=1, or
    - req[idx]=0, or
    - hold_cnt==MAX_HOLD-1. For this case only, timeout=1 in the same cycle.
  - On release: ptr <= idx+1 (3-bit wrap, so 7→0); next state IDLE.
  - gnt drops on the cycle after release.
- Bubble: exactly one IDLE cycle with gnt=0 occurs between consecutive grants. This gives a guaranteed dead cycle on the shared resource.
- Simultaneous done and timeout: treat as done; timeout stays 0.
- Requests changing in IDLE: only the value sampled on the arbitration edge matters.
- Requests from non-owners in GRANT are ignored; they do not pre-empt.
- Fairness: under continuous all-ones req, grants rotate 0,1,…,7,0. Any persistent requester is served within 8 grants.
- Reset mid-GRANT: gnt clears on the next edge and ptr returns to 0.
- Invariants:
  - gnt is one-hot or zero at all times.
  - gnt_valid == |gnt.
  - gnt == 1<<gnt_idx whenever gnt_valid=1.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam N_REQ=8 and IDX_W=3.
  - A priority-rotate function returning the index of the first set bit at or after ptr.
- Sub-module: the existing decoder3to8 (enabled 3-to-8 decoder).
  - Instance inputs: A=idx, en=(state==GRANT).
  - Instance output drives gnt.
  - No other sub-modules.

Test Plan:
- Reset, then req=8'h00 for 5 cycles → gnt=0, gnt_valid=0, timeout=0 throughout.
- req=8'b0000_0100 from reset, done pulsed 3 cycles after grant → gnt=8'h04 and gnt_idx=2 on cycle 1; gnt=0 the cycle after done; ptr becomes 3.
- req=8'hFF held, done pulsed every 2nd grant cycle → owner sequence 0,1,2,…,7,0, with one gnt=0 bubble between each grant.
- req=8'h01 held, done never asserted, MAX_HOLD=16 → timeout pulses exactly once on the 16th grant cycle; gnt clears the next cycle; the next grant goes to 0 again (only requester), idx wrap checked.
- Owner 5 granted, req[5] deasserted while req[6]=1 → release on that cycle, one bubble cycle, then gnt=8'h40.
- rst asserted mid-grant (owner 3) with req=8'h88 → gnt=0 after the edge; after rst drops, grant goes to 3 (ptr=0 search finds 3 first).
